fixed_point_acc: RTL and testbench

Saturating fixed-point accumulator sitting directly downstream of the fixed-point adder.
- Consumes the adder's registered sum, valid strobe and overflow flag.
- Sums NUM_TERMS consecutive valid samples with per-step saturation.
- Emits one registered result per batch, plus a sticky saturation flag for that batch.

---
 rtl/fixed_point_pkg.sv | 33 +++
 rtl/fixed_point_sat_add.sv | 25 ++
 rtl/fixed_point_acc.sv | 114 +++++++++++
 tb/tb_fixed_point_acc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: two's-complement range limits and a
// saturating clamp usable by any fixed-point block up to 31 bits wide.
package fixed_point_pkg;

  // Width of the intermediate used by the helpers; wide enough for a
  // WIDTH+1 bit sum when WIDTH is at most 31.
  localparam int FXP_CALC_W = 32;

  // Largest representable value of a signed word of the given width.
  function automatic logic signed [FXP_CALC_W-1:0] fxp_max(input int width);
    return (32'sd1 <<< (width - 1)) - 32'sd1;
  endfunction

  // Smallest representable value of a signed word of the given width.
  function automatic logic signed [FXP_CALC_W-1:0] fxp_min(input int width);
    return -(32'sd1 <<< (width - 1));
  endfunction

  // True when val does not fit in a signed word of the given width.
  function automatic logic fxp_out_of_range(input logic signed [FXP_CALC_W-1:0] val,
                                            input int width);
    return (val > fxp_max(width)) || (val < fxp_min(width));
  endfunction

  // Clamp val into the signed range of the given width.
  function automatic logic signed [FXP_CALC_W-1:0] fxp_clamp(input logic signed [FXP_CALC_W-1:0] val,
                                                             input int width);
    if (val > fxp_max(width)) return fxp_max(width);
    if (val < fxp_min(width)) return fxp_min(width);
    return val;
  endfunction

endpackage

// File: rtl/fixed_point_sat_add.sv
// Combinational saturating adder: acc + term computed one bit wider,
// then clamped back into WIDTH bits with a flag raised on any clamp.
module fixed_point_sat_add
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] acc,
  input  logic signed [WIDTH-1:0] term,
  output logic signed [WIDTH-1:0] sum,
  output logic                    sat
);

  logic signed [WIDTH:0]            raw;
  logic signed [FXP_CALC_W-1:0]     raw_ext;

  // Widen, add, then clamp; the wide sum can never wrap.
  always_comb begin
    raw     = {acc[WIDTH-1], acc} + {term[WIDTH-1], term};
    raw_ext = FXP_CALC_W'(raw);
    sum     = WIDTH'(fxp_clamp(raw_ext, WIDTH));
    sat     = fxp_out_of_range(raw_ext, WIDTH);
  end

endmodule

// File: rtl/fixed_point_acc.sv
// Saturating batch accumulator fed by the fixed-point adder. Sums
// NUM_TERMS accepted samples with a clamp on every step and emits one
// registered result per batch with a sticky saturation flag.
module fixed_point_acc
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int NUM_TERMS = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] VALUE_IN,
  input  logic             VALID_IN,
  input  logic             OVERFLOW_IN,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             VALID_OUT,
  output logic             SATURATED
);

  localparam int                      CNT_W    = $clog2(NUM_TERMS);
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(NUM_TERMS - 1);
  localparam logic signed [WIDTH-1:0] MAX_V    = WIDTH'(fxp_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_V    = WIDTH'(fxp_min(WIDTH));

  // The fraction position does not affect the arithmetic, but an
  // impossible format is still rejected at elaboration.
  if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_frac
    $error("fixed_point_acc: FRAC_BITS must lie in [0, WIDTH-1]");
  end
  if (NUM_TERMS < 2) begin : g_bad_terms
    $error("fixed_point_acc: NUM_TERMS must be at least 2");
  end
  if (WIDTH < 2 || WIDTH > 31) begin : g_bad_width
    $error("fixed_point_acc: WIDTH must lie in [2, 31]");
  end

  // An upstream overflow wrapped the sample, so its sign bit is the
  // opposite of the true direction: map it to the matching rail.
  function automatic logic signed [WIDTH-1:0] cond_term(input logic [WIDTH-1:0] value,
                                                        input logic             ovf);
    if (!ovf) return $signed(value);
    return value[WIDTH-1] ? MAX_V : MIN_V;
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic signed [WIDTH-1:0] acc_p0;
  logic                    flag_p0;

  logic signed [WIDTH-1:0] term;
  logic signed [WIDTH-1:0] acc_base;
  logic                    flag_base;
  logic signed [WIDTH-1:0] acc_next;
  logic                    add_sat;
  logic                    flag_next;

  logic [WIDTH-1:0]        value_p1;
  logic                    sat_p1;
  logic                    vld_p1;

  // Term 0 of a batch starts from a zero accumulator and a clean flag;
  // adding a term to zero cannot clamp, so this is a plain load.
  always_comb begin
    term      = cond_term(VALUE_IN, OVERFLOW_IN);
    acc_base  = (cnt_p0 == '0) ? '0   : acc_p0;
    flag_base = (cnt_p0 == '0) ? 1'b0 : flag_p0;
    flag_next = flag_base | OVERFLOW_IN | add_sat;
  end

  fixed_point_sat_add #(
    .WIDTH (WIDTH)
  ) u_sat_add (
    .acc  (acc_base),
    .term (term),
    .sum  (acc_next),
    .sat  (add_sat)
  );

  // p0 -> p1: accumulate accepted samples and register the batch result
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_p0   <= '0;
      acc_p0   <= '0;
      flag_p0  <= 1'b0;
      value_p1 <= '0;
      sat_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (CLEAR) begin
      cnt_p0  <= '0;
      flag_p0 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (VALID_IN) begin
        acc_p0  <= acc_next;
        flag_p0 <= flag_next;
        if (cnt_p0 == LAST_CNT) begin
          cnt_p0   <= '0;
          value_p1 <= acc_next;
          sat_p1   <= flag_next;
          vld_p1   <= 1'b1;
        end else begin
          cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
      end
    end
  end

  assign VALUE_OUT = value_p1;
  assign SATURATED = sat_p1;
  assign VALID_OUT = vld_p1;

endmodule

// File: tb/tb_fixed_point_acc.sv
// Bench for fixed_point_acc: directed scenarios followed by random
// traffic, every cycle compared against an integer reference model.
module tb_fixed_point_acc;

  localparam int WIDTH     = 8;
  localparam int FRAC_BITS = 3;
  localparam int NUM_TERMS = 4;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic [WIDTH-1:0] VALUE_IN;
  logic             VALID_IN;
  logic             OVERFLOW_IN;
  logic             CLEAR;
  logic [WIDTH-1:0] VALUE_OUT;
  logic             VALID_OUT;
  logic             SATURATED;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_cnt;
  int         m_acc;
  logic       m_flag;
  logic [7:0] exp_val;
  logic       exp_sat;
  logic       exp_vld;

  fixed_point_acc #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .NUM_TERMS (NUM_TERMS)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .VALUE_IN    (VALUE_IN),
    .VALID_IN    (VALID_IN),
    .OVERFLOW_IN (OVERFLOW_IN),
    .CLEAR       (CLEAR),
    .VALUE_OUT   (VALUE_OUT),
    .VALID_OUT   (VALID_OUT),
    .SATURATED   (SATURATED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_acc   = 0;
    m_flag  = 1'b0;
    exp_val = 8'h00;
    exp_sat = 1'b0;
    exp_vld = 1'b0;
  endtask

  // Batch arithmetic straight from the rules: saturate the term,
  // add with a clamp to [-128, 127], report after NUM_TERMS samples.
  task automatic model_step(input logic v, input logic [7:0] d, input logic ovf, input logic clr);
    int   term;
    int   s;
    logic f;
    exp_vld = 1'b0;
    if (clr) begin
      m_cnt  = 0;
      m_flag = 1'b0;
    end else if (v) begin
      if (ovf) term = d[7] ? 127 : -128;
      else     term = int'($signed(d));
      f = ovf;
      if (m_cnt == 0) begin
        s = term;
      end else begin
        s = m_acc + term;
        f = f | m_flag;
      end
      if (s > 127) begin
        s = 127;
        f = 1'b1;
      end else if (s < -128) begin
        s = -128;
        f = 1'b1;
      end
      m_acc  = s;
      m_flag = f;
      m_cnt++;
      if (m_cnt == NUM_TERMS) begin
        m_cnt   = 0;
        exp_vld = 1'b1;
        exp_val = s[7:0];
        exp_sat = f;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic ovf,
                       input logic clr, input string tag);
    VALID_IN    = v;
    VALUE_IN    = d;
    OVERFLOW_IN = ovf;
    CLEAR       = clr;
    model_step(v, d, ovf, clr);
    @(posedge CLK);
    #1;
    chk({tag, "_vld"}, 32'(VALID_OUT), 32'(exp_vld));
    chk({tag, "_val"}, 32'(VALUE_OUT), 32'(exp_val));
    chk({tag, "_sat"}, 32'(SATURATED), 32'(exp_sat));
  endtask

  task automatic smp(input logic [7:0] d, input string tag, input logic ovf = 1'b0);
    cycle(1'b1, d, ovf, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  initial begin
    RSTN        = 1'b0;
    VALUE_IN    = '0;
    VALID_IN    = 1'b0;
    OVERFLOW_IN = 1'b0;
    CLEAR       = 1'b0;
    model_reset();

    // Reset state, visible before any clock edge
    #2;
    chk("rst_val", 32'(VALUE_OUT), 32'h00);
    chk("rst_vld", 32'(VALID_OUT), 32'h0);
    chk("rst_sat", 32'(SATURATED), 32'h0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    idle("post_rst");

    // Nominal batch
    smp(8'h08, "nom0"); smp(8'h10, "nom1"); smp(8'hF8, "nom2"); smp(8'h04, "nom3");
    chk("nom_result", 32'(VALUE_OUT), 32'h14);
    chk("nom_pulse",  32'(VALID_OUT), 32'h1);
    chk("nom_sat",    32'(SATURATED), 32'h0);
    idle("nom_end");
    chk("nom_pulse_one_cycle", 32'(VALID_OUT), 32'h0);

    // Per-step clamp
    smp(8'h70, "clp0"); smp(8'h70, "clp1"); smp(8'hF0, "clp2"); smp(8'h08, "clp3");
    chk("clamp_result", 32'(VALUE_OUT), 32'h77);
    chk("clamp_sat",    32'(SATURATED), 32'h1);

    // Upstream overflow to MAX and to MIN
    smp(8'h90, "ovp0", 1'b1); smp(8'h00, "ovp1"); smp(8'h00, "ovp2"); smp(8'hF8, "ovp3");
    chk("ovf_pos_result", 32'(VALUE_OUT), 32'h77);
    chk("ovf_pos_sat",    32'(SATURATED), 32'h1);
    smp(8'h70, "ovn0", 1'b1); smp(8'h00, "ovn1"); smp(8'h00, "ovn2"); smp(8'hF8, "ovn3");
    chk("ovf_neg_result", 32'(VALUE_OUT), 32'h80);
    chk("ovf_neg_sat",    32'(SATURATED), 32'h1);
    idle("ovf_end");

    // CLEAR drops the partial batch and a coincident sample; gaps are harmless
    smp(8'h08, "clr0"); smp(8'h08, "clr1");
    cycle(1'b1, 8'h40, 1'b0, 1'b1, "clr_hit");
    smp(8'h08, "gap0"); idle("gap_i0");
    smp(8'h08, "gap1"); idle("gap_i1"); idle("gap_i2");
    smp(8'h08, "gap2"); idle("gap_i3");
    smp(8'h08, "gap3");
    chk("clear_result", 32'(VALUE_OUT), 32'h20);
    chk("clear_pulse",  32'(VALID_OUT), 32'h1);
    chk("clear_sat",    32'(SATURATED), 32'h0);

    // Saturating batch, then back-to-back batches with no bubble
    smp(8'h7F, "pre0"); smp(8'h7F, "pre1"); smp(8'h00, "pre2"); smp(8'h00, "pre3");
    for (int i = 0; i < 8; i++) begin
      smp(8'h04, "b2b");
      if (i == 3 || i == 7) begin
        chk("b2b_pulse",  32'(VALID_OUT), 32'h1);
        chk("b2b_result", 32'(VALUE_OUT), 32'h10);
        chk("b2b_sat",    32'(SATURATED), 32'h0);
      end else begin
        chk("b2b_no_pulse", 32'(VALID_OUT), 32'h0);
      end
    end

    // Asynchronous reset mid-batch
    smp(8'h02, "ar0"); smp(8'h02, "ar1"); smp(8'h02, "ar2");
    VALID_IN = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    chk("arst_val", 32'(VALUE_OUT), 32'h00);
    chk("arst_vld", 32'(VALID_OUT), 32'h0);
    chk("arst_sat", 32'(SATURATED), 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    chk("arst_hold_val", 32'(VALUE_OUT), 32'h00);
    RSTN = 1'b1;
    smp(8'h02, "rel0"); smp(8'h02, "rel1"); smp(8'h02, "rel2"); smp(8'h02, "rel3");
    chk("arst_result", 32'(VALUE_OUT), 32'h08);
    chk("arst_pulse",  32'(VALID_OUT), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 75),
            8'($urandom),
            ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 4),
            "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
